// File: rtl/nibble_add_sequencer.sv
// ============================================================================
// Module      : nibble_add_sequencer
// Description : W-bit add/subtract stepped one 4-bit lookahead slice per clock,
//               LSB nibble first. Optional macro: NIBBLE_ADD_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_add_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] Data1,
    input  logic [4*NIBBLES-1:0] Data2,
    input  logic                 Sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] Result,
    output logic                 CF,
    output logic                 OF,
    output logic                 ZF
);

    localparam int                 W      = 4 * NIBBLES;
    localparam int                 C_IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [C_IDXW-1:0]  C_LAST = C_IDXW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_carry;
    logic [C_IDXW-1:0] r_idx;
    logic              r_out_valid;

    logic [3:0]        w_a_nib;
    logic [3:0]        w_b_nib;
    logic [3:0]        w_g;
    logic [3:0]        w_p;
    logic [4:0]        w_c;
    logic [3:0]        w_sum;
    logic [W-1:0]      w_final;

    // Operand nibble select for the current lane
    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == C_IDXW'(i)) begin
                w_a_nib = r_a[4*i +: 4];
                w_b_nib = r_b[4*i +: 4];
            end
        end
    end

    // Generate/propagate carry lookahead, all carries flattened from c0
    assign w_g    = w_a_nib & w_b_nib;
    assign w_p    = w_a_nib ^ w_b_nib;
    assign w_c[0] = r_carry;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_sum  = w_p ^ w_c[3:0];

`ifdef NIBBLE_ADD_SAT_EN
    localparam logic [W-1:0] C_SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] C_SAT_NEG = {1'b1, {(W-1){1'b0}}};
    assign w_final = OF ? (r_a[W-1] ? C_SAT_NEG : C_SAT_POS) : Result;
`else
    assign w_final = Result;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)                   w_state_nxt = S_RUN;
            S_RUN:   if (r_idx == C_LAST)            w_state_nxt = S_DONE;
            S_DONE:  if (r_out_valid && out_ready)   w_state_nxt = S_IDLE;
            default:                                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            Result      <= '0;
            CF          <= 1'b0;
            OF          <= 1'b0;
            ZF          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= Data1;
                        r_b     <= Sub ? ~Data2 : Data2;
                        r_carry <= Sub;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == C_IDXW'(i)) Result[4*i +: 4] <= w_sum;
                    end
                    r_carry <= w_c[4];
                    if (r_idx == C_LAST) begin
                        CF <= w_c[4];
                        OF <= w_c[3] ^ w_c[4];
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // Entry cycle finalises Result/ZF before out_valid rises
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        Result      <= w_final;
                        ZF          <= (w_final == '0);
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_sequencer.sv
// ============================================================================
// Module      : tb_nibble_add_sequencer
// Description : Directed self-checking bench for nibble_add_sequencer
//               (NIBBLES=4 and NIBBLES=1 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_add_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Data1;
    logic [15:0] Data2;
    logic        Sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Result;
    logic        CF;
    logic        OF;
    logic        ZF;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  Data1_1;
    logic [3:0]  Data2_1;
    logic        Sub1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  Result1;
    logic        CF1;
    logic        OF1;
    logic        ZF1;

    int errors = 0;
    int checks = 0;

    nibble_add_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Data1(Data1), .Data2(Data2), .Sub(Sub), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .CF(CF), .OF(OF), .ZF(ZF)
    );

    nibble_add_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .Data1(Data1_1), .Data2(Data2_1), .Sub(Sub1), .out_valid(out_valid1),
        .out_ready(out_ready1), .Result(Result1), .CF(CF1), .OF(OF1), .ZF(ZF1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full operation on the 4-nibble instance, checking result, flags, latency
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] exp_r, input logic exp_cf,
                          input logic exp_of, input logic exp_zf);
        int lat;
        @(negedge clk);
        Data1 = a; Data2 = b; Sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        Data1 = 16'hDEAD; Data2 = 16'hBEEF; Sub = ~s;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("FAIL %s latency: got %0d expected 5", name, lat);
        end
        checks++;
        if (Result !== exp_r) begin
            errors++; $display("FAIL %s Result: got %h expected %h", name, Result, exp_r);
        end
        checks++;
        if ({CF, OF, ZF} !== {exp_cf, exp_of, exp_zf}) begin
            errors++; $display("FAIL %s flags CF/OF/ZF: got %b%b%b expected %b%b%b",
                               name, CF, OF, ZF, exp_cf, exp_of, exp_zf);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL %s release: got out_valid=%b in_ready=%b expected 0/1",
                               name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Data1 = '0; Data2 = '0; Sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; Data1_1 = '0; Data2_1 = '0; Sub1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset handshake: got in_ready=%b out_valid=%b expected 1/0",
                               in_ready, out_valid);
        end
        checks++;
        if (Result !== 16'h0 || {CF, OF, ZF} !== 3'b000) begin
            errors++; $display("FAIL reset outputs: got R=%h flags=%b%b%b expected 0000/000",
                               Result, CF, OF, ZF);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_add();
        run_op("add_1234_0fcc", 16'h1234, 16'h0FCC, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0);
        run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef NIBBLE_ADD_SAT_EN
        run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
        run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`endif
    endtask

    task automatic test_sub();
        run_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef NIBBLE_ADD_SAT_EN
        run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
        run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
        run_op("sub_1234_1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        Data1 = 16'h1234; Data2 = 16'h0FCC; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 Data1 = 16'hAAAA; Data2 = 16'h1111;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== 16'h2200
                || {CF, OF, ZF} !== 3'b000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b R=%h flags=%b%b%b expected 1/0/2200/000",
                         k, out_valid, in_ready, Result, CF, OF, ZF);
            end
            @(posedge clk); #1;
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: got ov=%b ir=%b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 5 || Result !== 16'hBBBB || {CF, OF, ZF} !== 3'b000) begin
            errors++; $display("FAIL bp_next_op: got lat=%0d R=%h flags=%b%b%b expected 5/bbbb/000",
                               lat, Result, CF, OF, ZF);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        Data1 = 16'h1111; Data2 = 16'h2222; Sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (Result !== 16'h0 || {CF, OF, ZF} !== 3'b000 || out_valid !== 1'b0
            || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_run: got R=%h flags=%b%b%b ov=%b ir=%b expected 0/000/0/1",
                               Result, CF, OF, ZF, out_valid, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
        end
        run_op("after_reset_1_1", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_nibble();
        int lat;
        @(negedge clk);
        Data1_1 = 4'h9; Data2_1 = 4'h9; Sub1 = 1'b0; in_valid1 = 1'b1;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL n1_latency: got %0d expected 2", lat);
        end
        checks++;
`ifdef NIBBLE_ADD_SAT_EN
        if (Result1 !== 4'h8 || {CF1, OF1, ZF1} !== 3'b110) begin
            errors++; $display("FAIL n1_9p9: got R=%h flags=%b%b%b expected 8/110",
                               Result1, CF1, OF1, ZF1);
        end
`else
        if (Result1 !== 4'h2 || {CF1, OF1, ZF1} !== 3'b110) begin
            errors++; $display("FAIL n1_9p9: got R=%h flags=%b%b%b expected 2/110",
                               Result1, CF1, OF1, ZF1);
        end
`endif
        @(negedge clk) out_ready1 = 1'b1;
        @(posedge clk);
        #1 out_ready1 = 1'b0;
        checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
            errors++; $display("FAIL n1_release: got ov=%b ir=%b expected 0/1", out_valid1, in_ready1);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_single_nibble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
